// File: rtl/ahb_slave_mux_dec.sv
// AHB-Lite address decoder and response multiplexer: one master, four slaves and a
// built-in default slave that answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR.
//
// Default-slave states:
//   state | meaning
//   IDLE  | no error in progress; OKAY with zero wait states
//   ERR1  | first error cycle: HREADY=0, HRESP=1
//   ERR2  | second error cycle: HREADY=1, HRESP=1
module ahb_slave_mux_dec #(
  parameter logic [31:0] BASE0 = 32'h0000_0000,
  parameter logic [31:0] MASK0 = 32'hFFFF_0000,
  parameter logic [31:0] BASE1 = 32'h2000_0000,
  parameter logic [31:0] MASK1 = 32'hFFFF_0000,
  parameter logic [31:0] BASE2 = 32'h4000_0000,
  parameter logic [31:0] MASK2 = 32'hFFFF_F000,
  parameter logic [31:0] BASE3 = 32'h4000_1000,
  parameter logic [31:0] MASK3 = 32'hFFFF_F000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  output logic        HSEL_S0,
  output logic        HSEL_S1,
  output logic        HSEL_S2,
  output logic        HSEL_S3,
  input  logic        HREADYOUT_S0,
  input  logic        HREADYOUT_S1,
  input  logic        HREADYOUT_S2,
  input  logic        HREADYOUT_S3,
  input  logic [31:0] HRDATA_S0,
  input  logic [31:0] HRDATA_S1,
  input  logic [31:0] HRDATA_S2,
  input  logic [31:0] HRDATA_S3,
  input  logic        HRESP_S0,
  input  logic        HRESP_S1,
  input  logic        HRESP_S2,
  input  logic        HRESP_S3,
  input  logic        HEXOKAY_S0,
  input  logic        HEXOKAY_S1,
  input  logic        HEXOKAY_S2,
  input  logic        HEXOKAY_S3,
  output logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        HEXOKAY
);

  typedef enum logic [2:0] {D_S0, D_S1, D_S2, D_S3, D_DEF, D_NONE} dsel_t;
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} def_state_t;

  logic [3:0] match;
  logic [3:0] hsel;
  logic       no_match;
  logic       err_entry;
  logic       def_hready;
  logic       def_hresp;
  dsel_t      asel;
  dsel_t      dsel;
  def_state_t def_state;

  assign match[0] = ((HADDR & MASK0) == BASE0);
  assign match[1] = ((HADDR & MASK1) == BASE1);
  assign match[2] = ((HADDR & MASK2) == BASE2);
  assign match[3] = ((HADDR & MASK3) == BASE3);
  assign no_match = ~|match;

  // Fixed priority so overlapping regions resolve to the lowest index.
  always_comb begin
    hsel = 4'b0000;
    asel = D_DEF;
    if (match[0]) begin
      hsel = 4'b0001;
      asel = D_S0;
    end else if (match[1]) begin
      hsel = 4'b0010;
      asel = D_S1;
    end else if (match[2]) begin
      hsel = 4'b0100;
      asel = D_S2;
    end else if (match[3]) begin
      hsel = 4'b1000;
      asel = D_S3;
    end
  end

  assign HSEL_S0 = hsel[0];
  assign HSEL_S1 = hsel[1];
  assign HSEL_S2 = hsel[2];
  assign HSEL_S3 = hsel[3];

  assign err_entry = HREADY & no_match & HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel <= D_NONE;
    end else if (HREADY) begin
      dsel <= asel;
    end
  end

  // HREADY/HRESP for the default slave are registered next to the state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      def_state  <= IDLE;
      def_hready <= 1'b1;
      def_hresp  <= 1'b0;
    end else begin
      case (def_state)
        IDLE: begin
          if (err_entry) begin
            def_state  <= ERR1;
            def_hready <= 1'b0;
            def_hresp  <= 1'b1;
          end
        end
        ERR1: begin
          def_state  <= ERR2;
          def_hready <= 1'b1;
          def_hresp  <= 1'b1;
        end
        ERR2: begin
          if (err_entry) begin
            def_state  <= ERR1;
            def_hready <= 1'b0;
            def_hresp  <= 1'b1;
          end else begin
            def_state  <= IDLE;
            def_hready <= 1'b1;
            def_hresp  <= 1'b0;
          end
        end
        default: begin
          def_state  <= IDLE;
          def_hready <= 1'b1;
          def_hresp  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    HREADY  = 1'b1;
    HRDATA  = 32'h0;
    HRESP   = 1'b0;
    HEXOKAY = 1'b0;
    case (dsel)
      D_S0: begin
        HREADY  = HREADYOUT_S0;
        HRDATA  = HRDATA_S0;
        HRESP   = HRESP_S0;
        HEXOKAY = HEXOKAY_S0;
      end
      D_S1: begin
        HREADY  = HREADYOUT_S1;
        HRDATA  = HRDATA_S1;
        HRESP   = HRESP_S1;
        HEXOKAY = HEXOKAY_S1;
      end
      D_S2: begin
        HREADY  = HREADYOUT_S2;
        HRDATA  = HRDATA_S2;
        HRESP   = HRESP_S2;
        HEXOKAY = HEXOKAY_S2;
      end
      D_S3: begin
        HREADY  = HREADYOUT_S3;
        HRDATA  = HRDATA_S3;
        HRESP   = HRESP_S3;
        HEXOKAY = HEXOKAY_S3;
      end
      D_DEF: begin
        HREADY = def_hready;
        HRESP  = def_hresp;
      end
      default: begin
        HREADY  = 1'b1;
        HRDATA  = 32'h0;
        HRESP   = 1'b0;
        HEXOKAY = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_mux_dec.sv
// Bench for ahb_slave_mux_dec: a vector table checked through an expected-response queue,
// plus hand sequences for pipelining across wait states, back-to-back errors and reset.
module tb_ahb_slave_mux_dec;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3;
  logic [3:0]  s_ready;
  logic [3:0]  s_resp;
  logic [3:0]  s_exok;
  logic [31:0] s_rdata [4];
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HEXOKAY;

  int n_checks = 0;
  int n_err    = 0;

  always #5 HCLK = ~HCLK;

  ahb_slave_mux_dec dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL_S0(HSEL_S0), .HSEL_S1(HSEL_S1), .HSEL_S2(HSEL_S2), .HSEL_S3(HSEL_S3),
    .HREADYOUT_S0(s_ready[0]), .HREADYOUT_S1(s_ready[1]),
    .HREADYOUT_S2(s_ready[2]), .HREADYOUT_S3(s_ready[3]),
    .HRDATA_S0(s_rdata[0]), .HRDATA_S1(s_rdata[1]),
    .HRDATA_S2(s_rdata[2]), .HRDATA_S3(s_rdata[3]),
    .HRESP_S0(s_resp[0]), .HRESP_S1(s_resp[1]), .HRESP_S2(s_resp[2]), .HRESP_S3(s_resp[3]),
    .HEXOKAY_S0(s_exok[0]), .HEXOKAY_S1(s_exok[1]),
    .HEXOKAY_S2(s_exok[2]), .HEXOKAY_S3(s_exok[3]),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .HEXOKAY(HEXOKAY)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    int          waits;
    bit          serr;
    bit          exok;
    logic [3:0]  exp_hsel;
    int          exp_idx;    // 0..3 slave, 4 default slave
    int          exp_nwait;
    bit          exp_wresp;
    bit          exp_resp;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          nwait;
    bit          wresp;
    bit          resp;
    bit          exokay;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [1:0] t, input int w,
                              input bit se, input bit ex, input logic [3:0] hs,
                              input int idx, input int nw, input bit wr, input bit r);
    vec_t v;
    v.addr = a; v.trans = t; v.waits = w; v.serr = se; v.exok = ex;
    v.exp_hsel = hs; v.exp_idx = idx; v.exp_nwait = nw; v.exp_wresp = wr; v.exp_resp = r;
    return v;
  endfunction

  task automatic randomize_slaves();
    for (int k = 0; k < 4; k++) s_rdata[k] = $urandom;
    s_ready = 4'hF;
    s_resp  = 4'h0;
    s_exok  = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //      addr          trans  w  se ex hsel    idx nw wr r
    vecs.push_back(mk(32'h0000_0104, 2'd2, 0, 0, 0, 4'b0001, 0, 0, 0, 0));
    vecs.push_back(mk(32'h4000_1008, 2'd2, 2, 0, 0, 4'b1000, 3, 2, 0, 0));
    vecs.push_back(mk(32'h2000_0000, 2'd3, 0, 0, 0, 4'b0010, 1, 0, 0, 0));
    vecs.push_back(mk(32'h4000_0FFC, 2'd2, 1, 0, 0, 4'b0100, 2, 1, 0, 0));
    vecs.push_back(mk(32'h4000_2000, 2'd2, 0, 0, 0, 4'b0000, 4, 1, 1, 1));
    vecs.push_back(mk(32'h0000_FFFF, 2'd2, 0, 0, 0, 4'b0001, 0, 0, 0, 0));
    vecs.push_back(mk(32'h0001_0000, 2'd2, 0, 0, 0, 4'b0000, 4, 1, 1, 1));
    vecs.push_back(mk(32'h2000_0040, 2'd2, 1, 1, 0, 4'b0010, 1, 1, 1, 1));
    vecs.push_back(mk(32'h0000_0200, 2'd2, 0, 0, 1, 4'b0001, 0, 0, 0, 0));
    vecs.push_back(mk(32'h6000_0000, 2'd0, 0, 0, 0, 4'b0000, 4, 0, 0, 0));
    vecs.push_back(mk(32'h4000_0010, 2'd1, 0, 0, 0, 4'b0100, 2, 0, 0, 0));
    vecs.push_back(mk(32'h2001_0000, 2'd2, 0, 0, 0, 4'b0000, 4, 1, 1, 1));
    vecs.push_back(mk(32'h4000_1FFC, 2'd3, 0, 0, 1, 4'b1000, 3, 0, 0, 0));
    vecs.push_back(mk(32'h8000_0000, 2'd0, 0, 0, 0, 4'b0000, 4, 0, 0, 0));

    // Reset with random slave inputs; outputs must be the idle response.
    HRESETn = 1'b0;
    HADDR   = 32'h0000_0000;
    HTRANS  = 2'd0;
    randomize_slaves();
    s_ready = 4'($urandom);
    s_resp  = 4'($urandom);
    s_exok  = 4'hF;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("reset_ctrl", {HREADY, HRESP, HEXOKAY}, 3'b100);
    chk("reset_rdata", HRDATA, 32'h0);
    HADDR = 32'h6000_0000;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("post_reset_ctrl", {HREADY, HRESP, HEXOKAY}, 3'b100);
    chk("post_reset_rdata", HRDATA, 32'h0);

    foreach (vecs[i]) begin
      vec_t v;
      exp_t e;
      bit   done;
      int   nw;
      bit   wr_seen;
      v = vecs[i];
      @(posedge HCLK); #1;
      randomize_slaves();
      s_exok = v.exok ? 4'hF : 4'h0;
      HADDR  = v.addr;
      HTRANS = v.trans;
      @(negedge HCLK);
      chk($sformatf("v%0d_hsel", i), {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0}, v.exp_hsel);
      chk($sformatf("v%0d_addr_phase_resp", i), {HREADY, HRESP, HEXOKAY}, 3'b100);
      e.rdata  = (v.exp_idx < 4) ? s_rdata[v.exp_idx] : 32'h0;
      e.exokay = (v.exp_idx < 4) && v.exok;
      e.nwait  = v.exp_nwait;
      e.wresp  = v.exp_wresp;
      e.resp   = v.exp_resp;
      sb.push_back(e);

      @(posedge HCLK); #1;
      HTRANS  = 2'd0;
      HADDR   = 32'h6000_0000;
      done    = 1'b0;
      nw      = 0;
      wr_seen = 1'b0;
      for (int c = 0; c < 16 && !done; c++) begin
        if (c > 0) begin
          @(posedge HCLK); #1;
        end
        if (v.exp_idx < 4) begin
          s_ready[v.exp_idx] = (c < v.waits) ? 1'b0 : 1'b1;
          s_resp[v.exp_idx]  = v.serr;
        end
        @(negedge HCLK);
        if (HREADY === 1'b1) begin
          exp_t got;
          done = 1'b1;
          got  = sb.pop_front();
          chk($sformatf("v%0d_nwait", i), nw, got.nwait);
          chk($sformatf("v%0d_wait_resp", i), wr_seen, got.wresp);
          chk($sformatf("v%0d_resp", i), HRESP, got.resp);
          chk($sformatf("v%0d_rdata", i), HRDATA, got.rdata);
          chk($sformatf("v%0d_exokay", i), HEXOKAY, got.exokay);
        end else begin
          nw++;
          wr_seen = wr_seen | HRESP;
        end
      end
      if (!done) begin
        n_checks++;
        n_err++;
        $display("FAIL v%0d_timeout: HREADY never rose, required within 16 cycles", i);
        void'(sb.pop_front());
      end
    end

    // Pipelined read to S1 issued while S3 inserts two wait states.
    @(posedge HCLK); #1;
    randomize_slaves();
    HADDR  = 32'h4000_1008;
    HTRANS = 2'd2;
    @(negedge HCLK);
    chk("pipe_hsel_s3", {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0}, 4'b1000);
    @(posedge HCLK); #1;
    s_ready[3] = 1'b0;
    HADDR  = 32'h2000_0000;
    HTRANS = 2'd2;
    @(negedge HCLK);
    chk("pipe_wait1_ready", HREADY, 1'b0);
    chk("pipe_hsel_s1", {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0}, 4'b0010);
    chk("pipe_wait1_rdata_s3", HRDATA, s_rdata[3]);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("pipe_wait2_ready", HREADY, 1'b0);
    chk("pipe_wait2_rdata_s3", HRDATA, s_rdata[3]);
    @(posedge HCLK); #1;
    s_ready[3] = 1'b1;
    @(negedge HCLK);
    chk("pipe_s3_done", {HREADY, HRESP}, 2'b10);
    @(posedge HCLK); #1;
    HTRANS = 2'd0;
    HADDR  = 32'h6000_0000;
    @(negedge HCLK);
    chk("pipe_s1_ready", HREADY, 1'b1);
    chk("pipe_s1_rdata", HRDATA, s_rdata[1]);

    // Back-to-back unmapped NONSEQ: ERR1, ERR2, ERR1, ERR2, then OKAY.
    @(posedge HCLK); #1;
    HADDR  = 32'h6000_0000;
    HTRANS = 2'd2;
    @(posedge HCLK); #1;
    HADDR  = 32'h6000_0004;
    @(negedge HCLK);
    chk("b2b_err1_first", {HREADY, HRESP}, 2'b01);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("b2b_err2_first", {HREADY, HRESP}, 2'b11);
    @(posedge HCLK); #1;
    HTRANS = 2'd0;
    HADDR  = 32'h6000_0000;
    @(negedge HCLK);
    chk("b2b_err1_second", {HREADY, HRESP}, 2'b01);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("b2b_err2_second", {HREADY, HRESP}, 2'b11);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("b2b_back_to_okay", {HREADY, HRESP}, 2'b10);

    // Reset asserted mid-ERR1 takes effect immediately; FSM is IDLE afterwards.
    @(posedge HCLK); #1;
    HADDR  = 32'h6000_0000;
    HTRANS = 2'd2;
    @(posedge HCLK); #1;
    HTRANS = 2'd0;
    @(negedge HCLK);
    chk("rst_mid_err1_before", {HREADY, HRESP}, 2'b01);
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_mid_err1_now", {HREADY, HRESP, HEXOKAY}, 3'b100);
    chk("rst_mid_err1_rdata", HRDATA, 32'h0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("rst_mid_err1_after", {HREADY, HRESP}, 2'b10);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("rst_mid_err1_idle", {HREADY, HRESP}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
